// File: rtl/busca_instrucao_pkg.sv
// Shared definitions for the processor front end: opcodes, fetch FSM states
// and the encoding of the CP source select.
package pkg_proc;

    localparam logic [3:0] OP_JUMP   = 4'b1011;
    localparam logic [3:0] OP_BRANCH = 4'b1100;

    typedef enum logic [1:0] {
        INICIO = 2'd0,
        REQ    = 2'd1,
        PRONTO = 2'd2
    } estado_t;

    // FonteCP: 0 selects the ULA result, 1 selects the jump field of IR
    localparam logic FONTE_ULA = 1'b0;
    localparam logic FONTE_IR  = 1'b1;

endpackage

// File: rtl/busca_instrucao_registrador_cp.sv
// Program counter with a one-deep pending target. While a read is in flight
// the CP must keep addressing memory, so writes are parked until the ack.
module registrador_cp
    import pkg_proc::*;
#(
    parameter int             AW       = 8,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          em_req,
    input  logic          em_pronto,
    input  logic          ack,
    input  logic          escrita,
    input  logic [AW-1:0] alvo,
    output logic [AW-1:0] cp
);

    logic [AW-1:0] cp_q, cp_d;
    logic [AW-1:0] pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;

    // Priority: direct write when idle; during a fetch the newest target
    // (same-cycle write, then parked one) beats the sequential increment.
    always_comb begin
        cp_d       = cp_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (em_pronto && escrita) begin
            cp_d = alvo;
        end else if (em_req) begin
            if (ack) begin
                pend_vld_d = 1'b0;
                if (escrita) begin
                    cp_d = alvo;
                end else if (pend_vld_q) begin
                    cp_d = pend_q;
                end else begin
                    cp_d = cp_q + AW'(1);
                end
            end else if (escrita) begin
                pend_vld_d = 1'b1;
                pend_d     = alvo;
            end
        end
    end

    // State registers for CP and the parked target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cp_q       <= RESET_PC;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            cp_q       <= cp_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    assign cp = cp_q;

endmodule

// File: rtl/busca_instrucao.sv
// Multicycle instruction fetch: runs the memory read handshake, holds IR,
// flags fetch timeouts and hands the opcode to the control unit.
module busca_instrucao
    import pkg_proc::*;
#(
    parameter int             AW       = 8,
    parameter int             DW       = 16,
    parameter logic [AW-1:0]  RESET_PC = '0,
    parameter int             TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    input  logic          EscIR,
    input  logic          EscCP,
    input  logic          EscCondCP,
    input  logic          FonteCP,
    input  logic          ula_zero,
    input  logic [DW-1:0] ula_result,
    output logic [DW-1:0] ir,
    output logic [3:0]    opcode,
    output logic          ir_valido,
    output logic [AW-1:0] cp,
    output logic          erro
);

    localparam int             CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT);

    estado_t       estado_q, estado_d;
    logic [DW-1:0] ir_q, ir_d;
    logic          ir_valido_q, ir_valido_d;
    logic          mem_req_q, mem_req_d;
    logic          erro_q, erro_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          esc_cp;
    logic [AW-1:0] alvo;
    logic          unused_ula;

    assign esc_cp     = EscCP | (EscCondCP & ula_zero);
    assign alvo       = (FonteCP == FONTE_IR) ? ir_q[AW-1:0] : ula_result[AW-1:0];
    assign unused_ula = ^ula_result[DW-1:AW];

    // Next-state logic for the fetch FSM, IR and timeout supervision
    always_comb begin
        estado_d    = estado_q;
        ir_d        = ir_q;
        ir_valido_d = ir_valido_q;
        mem_req_d   = mem_req_q;
        erro_d      = erro_q;
        cnt_d       = cnt_q;
        case (estado_q)
            INICIO: begin
                estado_d  = REQ;
                mem_req_d = 1'b1;
                cnt_d     = '0;
            end
            REQ: begin
                if (mem_ack) begin
                    ir_d        = mem_rdata;
                    ir_valido_d = 1'b1;
                    mem_req_d   = 1'b0;
                    estado_d    = PRONTO;
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (cnt_d == CNT_MAX) begin
                        erro_d = 1'b1;
                    end
                end
            end
            PRONTO: begin
                if (EscIR) begin
                    ir_valido_d = 1'b0;
                    mem_req_d   = 1'b1;
                    cnt_d       = '0;
                    estado_d    = REQ;
                end
            end
            default: begin
                estado_d  = INICIO;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Registered fetch state and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= INICIO;
            ir_q        <= '0;
            ir_valido_q <= 1'b0;
            mem_req_q   <= 1'b0;
            erro_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            estado_q    <= estado_d;
            ir_q        <= ir_d;
            ir_valido_q <= ir_valido_d;
            mem_req_q   <= mem_req_d;
            erro_q      <= erro_d;
            cnt_q       <= cnt_d;
        end
    end

    registrador_cp #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_registrador_cp (
        .clk       (clk),
        .rst_n     (rst_n),
        .em_req    (estado_q == REQ),
        .em_pronto (estado_q == PRONTO),
        .ack       (mem_ack),
        .escrita   (esc_cp),
        .alvo      (alvo),
        .cp        (cp)
    );

    assign mem_req   = mem_req_q;
    assign mem_addr  = cp;
    assign ir        = ir_q;
    assign opcode    = ir_q[DW-1:DW-4];
    assign ir_valido = ir_valido_q;
    assign erro      = erro_q;

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: directed scenarios followed by randomized
// control/handshake traffic, all compared against a behavioural model.
module tb_busca_instrucao;
    import pkg_proc::*;

    localparam int AW      = 8;
    localparam int DW      = 16;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic          EscIR = 1'b0, EscCP = 1'b0, EscCondCP = 1'b0, FonteCP = 1'b0;
    logic          ula_zero = 1'b0;
    logic [DW-1:0] ula_result = '0;
    logic [DW-1:0] ir;
    logic [3:0]    opcode;
    logic          ir_valido;
    logic [AW-1:0] cp;
    logic          erro;

    busca_instrucao #(
        .AW(AW), .DW(DW), .RESET_PC(8'h00), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .EscIR(EscIR), .EscCP(EscCP), .EscCondCP(EscCondCP), .FonteCP(FonteCP),
        .ula_zero(ula_zero), .ula_result(ula_result),
        .ir(ir), .opcode(opcode), .ir_valido(ir_valido), .cp(cp), .erro(erro)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: "iniciado" means the first post-reset clock happened;
    // a fetch is in flight while m_req is set, otherwise IR is being held.
    bit      m_iniciado;
    bit      m_req, m_vld, m_erro, m_pend_vld;
    int      m_cp, m_pend, m_espera;
    int      m_ir;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: obtido=0x%0h esperado=0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic modelo_reset();
        m_iniciado = 0; m_req = 0; m_vld = 0; m_erro = 0; m_pend_vld = 0;
        m_cp = 0; m_pend = 0; m_espera = 0; m_ir = 0;
    endtask

    task automatic modelo_passo(input bit escir, input bit esccp, input bit esccond, input bit fonte,
                                input bit zero, input int result, input bit ack, input int rdata);
        bit escreve;
        int tgt;
        escreve = esccp || (esccond && zero);
        tgt = fonte ? (m_ir % 256) : (result % 256);
        if (!m_iniciado) begin
            m_iniciado = 1; m_req = 1; m_espera = 0;
        end else if (m_req) begin
            if (escreve) begin
                m_pend_vld = 1; m_pend = tgt;
            end
            if (ack) begin
                m_ir = rdata; m_vld = 1; m_req = 0;
                m_cp = m_pend_vld ? m_pend : (m_cp + 1) % 256;
                m_pend_vld = 0;
            end else begin
                if (m_espera < TIMEOUT) m_espera++;
                if (m_espera >= TIMEOUT) m_erro = 1;
            end
        end else begin
            if (escreve) m_cp = tgt;
            if (escir) begin
                m_vld = 0; m_req = 1; m_espera = 0;
            end
        end
    endtask

    task automatic compara();
        verifica("cp", 32'(cp), 32'(m_cp));
        verifica("ir", 32'(ir), 32'(m_ir));
        verifica("opcode", 32'(opcode), 32'(m_ir / 4096));
        verifica("ir_valido", 32'(ir_valido), 32'(m_vld));
        verifica("mem_req", 32'(mem_req), 32'(m_req));
        verifica("erro", 32'(erro), 32'(m_erro));
        if (m_req) verifica("mem_addr", 32'(mem_addr), 32'(m_cp));
    endtask

    task automatic ciclo(input bit escir, input bit esccp, input bit esccond, input bit fonte,
                         input bit zero, input logic [15:0] result, input bit ack, input logic [15:0] rdata);
        EscIR = escir; EscCP = esccp; EscCondCP = esccond; FonteCP = fonte;
        ula_zero = zero; ula_result = result; mem_ack = ack; mem_rdata = rdata;
        @(posedge clk);
        modelo_passo(escir, esccp, esccond, fonte, zero, int'(result), ack, int'(rdata));
        #1;
        compara();
    endtask

    // Reset asserted away from the clock edge, spanning one edge, with ack held high
    task automatic aplica_reset();
        rst_n = 1'b0;
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        EscIR = 0; EscCP = 0; EscCondCP = 0;
        #1;
        modelo_reset();
        compara();
        #10;
        compara();
        rst_n = 1'b1;
        mem_ack = 1'b0;
    endtask

    initial begin
        // 1. reset and first fetch
        #1;
        aplica_reset();
        verifica("rst_cp", 32'(cp), 32'h00);
        ciclo(0, 0, 0, 0, 0, 16'h0, 0, 16'h0);
        verifica("t1_req", 32'(mem_req), 32'h1);
        verifica("t1_addr", 32'(mem_addr), 32'h00);
        ciclo(0, 0, 0, 0, 0, 16'h0, 0, 16'h0);
        ciclo(0, 0, 0, 0, 0, 16'h0, 0, 16'h0);
        ciclo(0, 0, 0, 0, 0, 16'h0, 1, 16'hB0A5);
        verifica("t1_ir", 32'(ir), 32'hB0A5);
        verifica("t1_op", 32'(opcode), 32'(OP_JUMP));
        verifica("t1_vld", 32'(ir_valido), 32'h1);
        verifica("t1_cp", 32'(cp), 32'h01);
        verifica("t1_req0", 32'(mem_req), 32'h0);

        // 2. conditional branch while holding IR
        ciclo(0, 0, 1, 0, 0, 16'h0040, 0, 16'h0);
        verifica("t2_nz", 32'(cp), 32'h01);
        ciclo(0, 0, 1, 0, 1, 16'h0040, 0, 16'h0);
        verifica("t2_z", 32'(cp), 32'h40);

        // 3. jump and fetch in the same cycle
        ciclo(1, 1, 0, 1, 0, 16'h0, 0, 16'h0);
        verifica("t3_cp", 32'(cp), 32'hA5);
        verifica("t3_vld", 32'(ir_valido), 32'h0);
        verifica("t3_addr", 32'(mem_addr), 32'hA5);
        ciclo(0, 0, 0, 0, 0, 16'h0, 1, 16'hC123);
        verifica("t3_op", 32'(opcode), 32'(OP_BRANCH));
        verifica("t3_inc", 32'(cp), 32'hA6);

        // 4. parked write during a fetch, EscIR ignored
        ciclo(1, 1, 0, 0, 0, 16'h0010, 0, 16'h0);
        verifica("t4_addr", 32'(mem_addr), 32'h10);
        ciclo(0, 1, 0, 0, 0, 16'h0080, 0, 16'h0);
        verifica("t4_hold", 32'(cp), 32'h10);
        ciclo(1, 0, 0, 0, 0, 16'h0, 0, 16'h0);
        ciclo(0, 0, 0, 0, 0, 16'h0, 1, 16'h1234);
        verifica("t4_cp", 32'(cp), 32'h80);
        verifica("t4_vld", 32'(ir_valido), 32'h1);

        // 5. wrap and timeout
        ciclo(1, 1, 0, 0, 0, 16'h00FF, 0, 16'h0);
        for (int i = 1; i <= 16; i++) begin
            ciclo(0, 0, 0, 0, 0, 16'h0, 0, 16'h0);
            if (i == 14) verifica("t5_cedo", 32'(erro), 32'h0);
            if (i == 15) verifica("t5_erro", 32'(erro), 32'h1);
        end
        ciclo(0, 0, 0, 0, 0, 16'h0, 1, 16'h5A5A);
        verifica("t5_wrap", 32'(cp), 32'h00);
        verifica("t5_ir", 32'(ir), 32'h5A5A);
        verifica("t5_sticky", 32'(erro), 32'h1);

        // 6. reset in the middle of a fetch, late ack ignored
        ciclo(1, 0, 0, 0, 0, 16'h0, 0, 16'h0);
        #3;
        aplica_reset();
        verifica("t6_erro", 32'(erro), 32'h0);
        ciclo(0, 0, 0, 0, 0, 16'h0, 1, 16'h7777);
        verifica("t6_ir", 32'(ir), 32'h0000);
        verifica("t6_cp", 32'(cp), 32'h00);
        verifica("t6_req", 32'(mem_req), 32'h1);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                #2;
                aplica_reset();
            end
            ciclo($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                  $urandom_range(0, 3) == 0, 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
